ctrl_bank_sched: RTL and testbench

CTRL_BANK_SCHED -- requirements
Module: ctrl_bank_sched

---
 rtl/ddr_pkg.sv | 34 +++
 rtl/ctrl_act_window.sv | 52 +++++
 rtl/ctrl_bank_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_ctrl_bank_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared FSM state, page classification codes and default timing for the bank scheduler
package ddr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_PRE_WAIT,
        ST_RP_WAIT,
        ST_ACT_WAIT,
        ST_RCD_WAIT,
        ST_CAS,
        ST_CLOSE_ALL
    } sched_state_t;

    // page_stat encoding
    localparam logic [1:0] PS_HIT   = 2'd0;
    localparam logic [1:0] PS_EMPTY = 2'd1;
    localparam logic [1:0] PS_MISS  = 2'd2;

    // default geometry and timing (in clock cycles)
    localparam int DEF_NUM_BANKS = 16;
    localparam int DEF_ROW_W     = 15;
    localparam int DEF_T_RRD     = 4;
    localparam int DEF_T_RP      = 11;
    localparam int DEF_T_RCD     = 11;
    localparam int DEF_T_RTP     = 6;
    localparam int DEF_T_WRP     = 20;
    localparam int DEF_T_FAW     = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ctrl_act_window.sv
// rtl/ctrl_act_window.sv - ACTIVATE spacing (tRRD) and four-activate window (tFAW) tracker
//
// Ports:
//   CK_t         clock, rising edge
//   reset_n      synchronous active-low reset
//   act_strobe   an ACTIVATE is being issued on this edge
//   act_allowed  an ACTIVATE issued on this edge would respect tRRD and tFAW
module ctrl_act_window #(
    parameter int T_RRD = 4,
    parameter int T_FAW = 16
) (
    input  logic CK_t,
    input  logic reset_n,
    input  logic act_strobe,
    output logic act_allowed
);

    localparam int RRD_W = $clog2(T_RRD + 1);
    localparam int FAW_W = $clog2(T_FAW + 1);
    localparam logic [RRD_W-1:0] RRD_SAT = RRD_W'(T_RRD);
    localparam logic [FAW_W-1:0] FAW_SAT = FAW_W'(T_FAW);
    localparam logic [RRD_W-1:0] RRD_ONE = RRD_W'(1);
    localparam logic [FAW_W-1:0] FAW_ONE = FAW_W'(1);

    // r_rrd_cnt: cycles since the last ACTIVATE, saturating at T_RRD.
    // r_age[i]:  age of the i-th most recent ACTIVATE, saturating at T_FAW;
    //            a saturated entry is indistinguishable from an empty one.
    logic [RRD_W-1:0] r_rrd_cnt;
    logic [FAW_W-1:0] r_age [4];

    function automatic logic [FAW_W-1:0] age_inc(input logic [FAW_W-1:0] a);
        return (a >= FAW_SAT) ? a : a + FAW_ONE;
    endfunction

    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            r_rrd_cnt <= RRD_SAT;
            for (int i = 0; i < 4; i++) r_age[i] <= FAW_SAT;
        end else if (act_strobe) begin
            r_rrd_cnt <= RRD_ONE;
            r_age[0]  <= FAW_ONE;
            for (int i = 1; i < 4; i++) r_age[i] <= age_inc(r_age[i-1]);
        end else begin
            if (r_rrd_cnt < RRD_SAT) r_rrd_cnt <= r_rrd_cnt + RRD_ONE;
            for (int i = 0; i < 4; i++) r_age[i] <= age_inc(r_age[i]);
        end
    end

    // The oldest of the last four activates must have left the window.
    assign act_allowed = (r_rrd_cnt >= RRD_SAT) && (r_age[3] >= FAW_SAT);

endmodule

// File: rtl/ctrl_bank_sched.sv
// rtl/ctrl_bank_sched.sv - per-bank open-row tracking and ACT/PRE/CAS sequencing for one request at a time
//
// Ports:
//   CK_t, reset_n            clock (rising edge), synchronous active-low reset
//   req_valid/req_ready      request handshake; req_bank, req_row, req_wr describe it
//   cas_done                 pulse: the CAS for the current request has issued
//   close_all                level: precharge every open bank (refresh entry)
//   act_valid, pre_valid     one-cycle ACTIVATE / PRECHARGE strobes on cmd_bank (cmd_row for ACT)
//   cas_go                   one-cycle strobe: row open, CAS may issue
//   page_stat                last request classification: 0 hit, 1 empty, 2 miss
//   all_closed               no bank open and the FSM idle
module ctrl_bank_sched
    import ddr_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int ROW_W     = DEF_ROW_W,
    parameter int T_RRD     = DEF_T_RRD,
    parameter int T_RP      = DEF_T_RP,
    parameter int T_RCD     = DEF_T_RCD,
    parameter int T_RTP     = DEF_T_RTP,
    parameter int T_WRP     = DEF_T_WRP,
    parameter int T_FAW     = DEF_T_FAW
) (
    input  logic                         CK_t,
    input  logic                         reset_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [$clog2(NUM_BANKS)-1:0] req_bank,
    input  logic [ROW_W-1:0]             req_row,
    input  logic                         req_wr,
    input  logic                         cas_done,
    input  logic                         close_all,
    output logic                         act_valid,
    output logic                         pre_valid,
    output logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
    output logic [ROW_W-1:0]             cmd_row,
    output logic                         cas_go,
    output logic [1:0]                   page_stat,
    output logic                         all_closed
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int CNT_W  = $clog2(max_int(T_WRP, T_RTP) + 1);
    localparam int TMR_W  = $clog2(max_int(T_RP, T_RCD) + 1);

    // Timer loads are two short of the nominal delay: one edge is spent
    // leaving the wait state and one issuing the strobe in the next state.
    // When closing, RP_WAIT returns straight to IDLE, so only one is saved.
    localparam logic [TMR_W-1:0] RP_LOAD       = TMR_W'(T_RP - 2);
    localparam logic [TMR_W-1:0] RP_CLOSE_LOAD = TMR_W'(T_RP - 1);
    localparam logic [TMR_W-1:0] RCD_LOAD      = TMR_W'(T_RCD - 2);
    localparam logic [TMR_W-1:0] TMR_ONE       = TMR_W'(1);
    // Bank counter reaches 0 one edge before PRECHARGE may issue.
    localparam logic [CNT_W-1:0] RTP_LOAD      = CNT_W'(T_RTP - 1);
    localparam logic [CNT_W-1:0] WRP_LOAD      = CNT_W'(T_WRP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    sched_state_t      r_state;
    logic [BANK_W-1:0] r_bank;
    logic [ROW_W-1:0]  r_row;
    logic              r_wr;
    logic              r_cas_sent;
    logic              r_closing;
    logic [TMR_W-1:0]  r_tmr;
    logic [NUM_BANKS-1:0] r_open;
    logic [ROW_W-1:0]  r_row_tab [NUM_BANKS];
    logic [CNT_W-1:0]  r_cnt     [NUM_BANKS];

    logic              r_act_valid;
    logic              r_pre_valid;
    logic              r_cas_go;
    logic [BANK_W-1:0] r_cmd_bank;
    logic [ROW_W-1:0]  r_cmd_row;
    logic [1:0]        r_page_stat;

    logic              w_act_allowed;
    logic              w_act_fire;
    logic              w_low_found;
    logic [BANK_W-1:0] w_low_bank;
    logic              w_others_open;

    ctrl_act_window #(
        .T_RRD (T_RRD),
        .T_FAW (T_FAW)
    ) u_act_window (
        .CK_t        (CK_t),
        .reset_n     (reset_n),
        .act_strobe  (w_act_fire),
        .act_allowed (w_act_allowed)
    );

    assign w_act_fire = (r_state == ST_ACT_WAIT) && w_act_allowed;

    // Lowest-index open bank, for ascending close-all order.
    always_comb begin
        w_low_found = 1'b0;
        w_low_bank  = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (r_open[i]) begin
                w_low_found = 1'b1;
                w_low_bank  = BANK_W'(i);
            end
        end
    end

    assign w_others_open = |(r_open & ~(NUM_BANKS'(1) << w_low_bank));

    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_bank      <= '0;
            r_row       <= '0;
            r_wr        <= 1'b0;
            r_cas_sent  <= 1'b0;
            r_closing   <= 1'b0;
            r_tmr       <= '0;
            r_open      <= '0;
            r_act_valid <= 1'b0;
            r_pre_valid <= 1'b0;
            r_cas_go    <= 1'b0;
            r_cmd_bank  <= '0;
            r_cmd_row   <= '0;
            r_page_stat <= PS_HIT;
            for (int i = 0; i < NUM_BANKS; i++) begin
                r_row_tab[i] <= '0;
                r_cnt[i]     <= '0;
            end
        end else begin
            r_act_valid <= 1'b0;
            r_pre_valid <= 1'b0;
            r_cas_go    <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - CNT_ONE;
            end

            case (r_state)
                ST_IDLE: begin
                    if (close_all) begin
                        r_state <= ST_CLOSE_ALL;
                    end else if (req_valid) begin
                        r_bank     <= req_bank;
                        r_row      <= req_row;
                        r_wr       <= req_wr;
                        r_cas_sent <= 1'b0;
                        r_state    <= ST_CLASSIFY;
                    end
                end
                ST_CLASSIFY: begin
                    if (!r_open[r_bank]) begin
                        r_page_stat <= PS_EMPTY;
                        r_state     <= ST_ACT_WAIT;
                    end else if (r_row_tab[r_bank] == r_row) begin
                        r_page_stat <= PS_HIT;
                        r_state     <= ST_CAS;
                    end else begin
                        r_page_stat <= PS_MISS;
                        r_state     <= ST_PRE_WAIT;
                    end
                end
                ST_PRE_WAIT: begin
                    if (r_cnt[r_bank] == '0) begin
                        r_pre_valid    <= 1'b1;
                        r_cmd_bank     <= r_bank;
                        r_open[r_bank] <= 1'b0;
                        r_tmr          <= RP_LOAD;
                        r_closing      <= 1'b0;
                        r_state        <= ST_RP_WAIT;
                    end
                end
                ST_RP_WAIT: begin
                    if (r_tmr == '0) r_state <= r_closing ? ST_IDLE : ST_ACT_WAIT;
                    else             r_tmr   <= r_tmr - TMR_ONE;
                end
                ST_ACT_WAIT: begin
                    if (w_act_fire) begin
                        r_act_valid       <= 1'b1;
                        r_cmd_bank        <= r_bank;
                        r_cmd_row         <= r_row;
                        r_open[r_bank]    <= 1'b1;
                        r_row_tab[r_bank] <= r_row;
                        r_tmr             <= RCD_LOAD;
                        r_state           <= ST_RCD_WAIT;
                    end
                end
                ST_RCD_WAIT: begin
                    if (r_tmr == '0) r_state <= ST_CAS;
                    else             r_tmr   <= r_tmr - TMR_ONE;
                end
                ST_CAS: begin
                    if (!r_cas_sent) begin
                        r_cas_go   <= 1'b1;
                        r_cas_sent <= 1'b1;
                    end else if (cas_done) begin
                        r_cnt[r_bank] <= r_wr ? WRP_LOAD : RTP_LOAD;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_CLOSE_ALL: begin
                    if (!w_low_found) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt[w_low_bank] == '0) begin
                        r_pre_valid        <= 1'b1;
                        r_cmd_bank         <= w_low_bank;
                        r_open[w_low_bank] <= 1'b0;
                        if (!w_others_open) begin
                            r_tmr     <= RP_CLOSE_LOAD;
                            r_closing <= 1'b1;
                            r_state   <= ST_RP_WAIT;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = reset_n && (r_state == ST_IDLE) && !close_all;
    assign all_closed = (r_open == '0) && (r_state == ST_IDLE);
    assign act_valid  = r_act_valid;
    assign pre_valid  = r_pre_valid;
    assign cas_go     = r_cas_go;
    assign cmd_bank   = r_cmd_bank;
    assign cmd_row    = r_cmd_row;
    assign page_stat  = r_page_stat;

endmodule

// File: tb/tb_ctrl_bank_sched.sv
// tb/tb_ctrl_bank_sched.sv - self-checking bench for ctrl_bank_sched against a cycle-arithmetic reference model
module tb_ctrl_bank_sched;

    localparam int NB    = 16;
    localparam int ROW_W = 15;
    localparam int T_RRD = 8;
    localparam int T_RP  = 3;
    localparam int T_RCD = 3;
    localparam int T_RTP = 4;
    localparam int T_WRP = 9;
    localparam int T_FAW = 36;

    logic             CK_t;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_bank;
    logic [ROW_W-1:0] req_row;
    logic             req_wr;
    logic             cas_done;
    logic             close_all;
    logic             act_valid;
    logic             pre_valid;
    logic [3:0]       cmd_bank;
    logic [ROW_W-1:0] cmd_row;
    logic             cas_go;
    logic [1:0]       page_stat;
    logic             all_closed;

    ctrl_bank_sched #(
        .NUM_BANKS (NB),    .ROW_W (ROW_W), .T_RRD (T_RRD), .T_RP (T_RP),
        .T_RCD     (T_RCD), .T_RTP (T_RTP), .T_WRP (T_WRP), .T_FAW (T_FAW)
    ) dut (
        .CK_t       (CK_t),      .reset_n    (reset_n),
        .req_valid  (req_valid), .req_ready  (req_ready),
        .req_bank   (req_bank),  .req_row    (req_row),
        .req_wr     (req_wr),    .cas_done   (cas_done),
        .close_all  (close_all), .act_valid  (act_valid),
        .pre_valid  (pre_valid), .cmd_bank   (cmd_bank),
        .cmd_row    (cmd_row),   .cas_go     (cas_go),
        .page_stat  (page_stat), .all_closed (all_closed)
    );

    initial CK_t = 1'b0;
    always #5 CK_t = ~CK_t;

    int cyc = 0;
    always @(posedge CK_t) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bank state in plain arrays, ACTIVATE history as edge numbers.
    bit m_open  [NB];
    int m_row   [NB];
    int m_casc  [NB];
    bit m_caswr [NB];
    int act_hist [$];

    bit s_act, s_pre, s_cas;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cas_to_pre(input int b);
        return m_caswr[b] ? T_WRP : T_RTP;
    endfunction

    // First edge >= t at which an ACTIVATE respects tRRD and tFAW.
    function automatic int act_earliest(input int t);
        int e = t;
        if (act_hist.size() > 0)  e = imax(e, act_hist[act_hist.size()-1] + T_RRD);
        if (act_hist.size() >= 4) e = imax(e, act_hist[act_hist.size()-4] + T_FAW);
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_open[i] = 0; m_row[i] = 0; m_casc[i] = -1000; m_caswr[i] = 0;
        end
        act_hist.delete();
    endtask

    task automatic step();
        @(negedge CK_t);
        s_act = act_valid; s_pre = pre_valid; s_cas = cas_go;
        if (s_act) act_hist.push_back(cyc);
        if (s_act || s_pre || s_cas) chk("strobe_excl", int'(s_act) + int'(s_pre) + int'(s_cas), 1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 300) begin step(); n++; end
        chk("ready_wait", req_ready, 1);
    endtask

    task automatic do_req(input int b, input int row, input bit wr, input int dly, input bit abort_pre);
        int exp_stat, t_acc, exp_pre, exp_act, exp_cas, got_pre, got_act, got_cas, n;
        wait_ready();
        if (!m_open[b])          exp_stat = 1;
        else if (m_row[b] == row) exp_stat = 0;
        else                      exp_stat = 2;
        exp_pre = -1; exp_act = -1;
        req_valid = 1; req_bank = 4'(b); req_row = ROW_W'(row); req_wr = wr;
        t_acc = cyc + 1;
        if (exp_stat == 2) exp_pre = imax(t_acc + 2, m_casc[b] + cas_to_pre(b));
        if (exp_stat == 1) exp_act = act_earliest(t_acc + 2);
        if (exp_stat == 2) exp_act = act_earliest(exp_pre + T_RP);
        exp_cas = (exp_stat == 0) ? t_acc + 2 : exp_act + T_RCD;
        step();
        req_valid = 0;
        step();
        chk("page_stat", page_stat, exp_stat);
        got_pre = -1; got_act = -1; got_cas = -1; n = 0;
        while (got_cas < 0 && n < 500) begin
            step();
            if (s_pre) begin got_pre = cyc; chk("pre_bank", cmd_bank, b); end
            if (s_act) begin got_act = cyc; chk("act_bank", cmd_bank, b); chk("act_row", cmd_row, row); end
            if (s_cas) got_cas = cyc;
            if (abort_pre && got_pre >= 0) break;
            n++;
        end
        chk("pre_cycle", got_pre, exp_pre);
        if (abort_pre) begin
            m_open[b] = 0;
            return;
        end
        chk("act_cycle", got_act, exp_act);
        chk("cas_cycle", got_cas, exp_cas);
        m_open[b] = 1; m_row[b] = row;
        repeat (dly) step();
        cas_done = 1;
        m_casc[b] = cyc + 1; m_caswr[b] = wr;
        step();
        cas_done = 0;
    endtask

    task automatic do_close(input bit with_req);
        int exp_p [$];
        int exp_b [$];
        int p, t_start, exp_idle, n, idx;
        wait_ready();
        close_all = 1;
        if (with_req) begin req_valid = 1; req_bank = 0; req_row = 'h77; req_wr = 0; end
        t_start = cyc + 1;
        p = t_start;
        for (int b = 0; b < NB; b++) begin
            if (m_open[b]) begin
                p = imax(p + 1, m_casc[b] + cas_to_pre(b));
                exp_p.push_back(p); exp_b.push_back(b);
            end
        end
        exp_idle = (exp_p.size() > 0) ? p + T_RP : t_start + 1;
        step();
        req_valid = 0;
        #1 chk("close_ready", req_ready, 0);
        idx = 0; n = 0;
        while (!all_closed && n < 600) begin
            step();
            if (s_pre) begin
                chk("close_pre_count", idx + 1 <= exp_p.size(), 1);
                if (idx < exp_p.size()) begin
                    chk("close_pre_cycle", cyc, exp_p[idx]);
                    chk("close_pre_bank", cmd_bank, exp_b[idx]);
                end
                idx++;
            end
            n++;
        end
        chk("close_idle_cycle", cyc, exp_idle);
        chk("close_pre_total", idx, exp_p.size());
        chk("close_hold_ready", req_ready, 0);
        close_all = 0;
        for (int b = 0; b < NB; b++) m_open[b] = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int rows [3];
        int r;
        rows = '{'h10, 'h20, 'h155};
        reset_n = 0; req_valid = 0; req_bank = 0; req_row = 0; req_wr = 0;
        cas_done = 0; close_all = 0;
        model_reset();

        repeat (3) step();
        chk("rst_ready", req_ready, 0);
        chk("rst_strobes", {act_valid, pre_valid, cas_go}, 0);
        reset_n = 1;
        #1;
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_all_closed", all_closed, 1);
        chk("post_rst_page_stat", page_stat, 0);

        do_req(3, 'h10, 0, 0, 0);           // empty
        do_req(3, 'h10, 0, 0, 0);           // hit
        do_req(3, 'h10, 1, 0, 0);           // write hit
        do_req(3, 'h20, 1, 0, 0);           // miss after write CAS
        do_close(0);
        for (int b = 0; b < 5; b++) do_req(b, 'h40 + b, 0, 0, 0);  // tRRD then tFAW bound
        do_close(1);                        // close_all wins over a request
        do_req(1, 'h11, 0, 0, 0);
        do_req(7, 'h17, 1, 1, 0);
        do_close(0);                        // bank 1 then bank 7

        do_req(7, 'h30, 0, 0, 0);
        do_req(7, 'h31, 0, 0, 1);           // miss, stop in RP_WAIT
        reset_n = 0;
        step();
        chk("midrst_strobes", {act_valid, pre_valid, cas_go}, 0);
        chk("midrst_ready", req_ready, 0);
        step();
        chk("midrst_strobes2", {act_valid, pre_valid, cas_go}, 0);
        reset_n = 1;
        model_reset();
        #1;
        chk("midrst_all_closed", all_closed, 1);
        chk("midrst_ready_after", req_ready, 1);
        do_req(7, 'h31, 0, 0, 0);           // must classify as empty

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) do_close(r[0]);
            else do_req($urandom_range(0, 5), rows[$urandom_range(0, 2)],
                        1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
